// File: rtl/grant_pkt_builder_if.sv
// AXI-Stream master channel carrying serialized GRANT header beats.
interface grant_pkt_builder_if;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [7:0]  m_axis_tkeep;

    modport master (
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast,
        output m_axis_tkeep,
        input  m_axis_tready
    );

    modport slave (
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        input  m_axis_tkeep,
        output m_axis_tready
    );
endinterface

// File: rtl/grant_pkt_builder.sv
// Pops grant entries from a FWFT FIFO and emits a 3-beat GRANT header.
// Define GRANT_DEDUP_EN to drop entries repeating the last sent grant.
module grant_pkt_builder (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 grant_pkt_empty_i,
    output logic                 grant_pkt_read_en_o,
    input  logic [94:0]          grant_pkt_data_i,
    grant_pkt_builder_if.master  m_axis,
    output logic [31:0]          grant_sent_count_o
);

    typedef struct packed {
        logic [13:0] peer_id;
        logic [13:0] local_id;
        logic [31:0] grant_offset;
        logic [31:0] message_length;
        logic [2:0]  prio;
    } entry_t;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
    localparam logic [1:0] BEAT1 = 2'd2;
    localparam logic [1:0] BEAT2 = 2'd3;

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    entry_t      entry_q;
    entry_t      in_entry;
    logic [31:0] cnt_q;
    logic        run_q;
    logic        hs;
    logic        last_hs;
    logic        pop;
    logic        drop;
    logic        accept;

    assign in_entry = entry_t'(grant_pkt_data_i);
    assign hs       = (state_q != IDLE) & m_axis.m_axis_tready;
    assign last_hs  = (state_q == BEAT2) & hs;

    // run_q holds off popping for the first cycle after reset release
    assign pop = run_q & ~grant_pkt_empty_i
               & ((state_q == IDLE) | last_hs);

`ifdef GRANT_DEDUP_EN
    logic [59:0] last_key_q;
    logic        last_vld_q;
    logic [59:0] cmp_key;
    logic        cmp_vld;
    logic [59:0] in_key;

    assign in_key = {in_entry.peer_id, in_entry.local_id,
                     in_entry.grant_offset};

    // a pop on the closing beat must see the packet finishing now
    assign cmp_key = last_hs
                   ? {entry_q.peer_id, entry_q.local_id,
                      entry_q.grant_offset}
                   : last_key_q;
    assign cmp_vld = last_hs | last_vld_q;
    assign drop    = pop & cmp_vld & (in_key == cmp_key);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            last_key_q <= '0;
            last_vld_q <= 1'b0;
        end else if (last_hs) begin
            last_key_q <= {entry_q.peer_id, entry_q.local_id,
                           entry_q.grant_offset};
            last_vld_q <= 1'b1;
        end
    end
`else
    assign drop = 1'b0;
`endif

    assign accept = pop & ~drop;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = BEAT0;
            BEAT0: if (hs)     state_d = BEAT1;
            BEAT1: if (hs)     state_d = BEAT2;
            BEAT2: if (hs)     state_d = accept ? BEAT0 : IDLE;
            default:           state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
            entry_q <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            if (accept)  entry_q <= in_entry;
            if (last_hs) cnt_q   <= cnt_q + 32'd1;
        end
    end

    always_comb begin
        m_axis.m_axis_tdata = '0;
        m_axis.m_axis_tkeep = '0;
        m_axis.m_axis_tlast = 1'b0;
        unique case (state_q)
            BEAT0: begin
                m_axis.m_axis_tdata = {2'b0, entry_q.peer_id,
                                       2'b0, entry_q.local_id,
                                       8'h11, 24'h0};
                m_axis.m_axis_tkeep = 8'hFF;
            end
            BEAT1: begin
                m_axis.m_axis_tdata = {entry_q.grant_offset,
                                       entry_q.message_length};
                m_axis.m_axis_tkeep = 8'hFF;
            end
            BEAT2: begin
                m_axis.m_axis_tdata = {5'b0, entry_q.prio, 56'h0};
                m_axis.m_axis_tkeep = 8'h80;
                m_axis.m_axis_tlast = 1'b1;
            end
            default: ;
        endcase
    end

    assign m_axis.m_axis_tvalid = (state_q != IDLE);
    assign grant_pkt_read_en_o  = pop;
    assign grant_sent_count_o   = cnt_q;

endmodule

// File: tb/tb_grant_pkt_builder.sv
// Scoreboard bench for grant_pkt_builder: directed entries, queued beats.
// Optional GRANT_DEDUP_EN changes the expected beats of the dedup case.
module tb_grant_pkt_builder;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        grant_pkt_empty_i;
    logic        grant_pkt_read_en_o;
    logic [94:0] grant_pkt_data_i;
    logic [31:0] grant_sent_count_o;

    grant_pkt_builder_if axis ();

    grant_pkt_builder dut (
        .ap_clk              (ap_clk),
        .ap_rst_n            (ap_rst_n),
        .grant_pkt_empty_i   (grant_pkt_empty_i),
        .grant_pkt_read_en_o (grant_pkt_read_en_o),
        .grant_pkt_data_i    (grant_pkt_data_i),
        .m_axis              (axis),
        .grant_sent_count_o  (grant_sent_count_o)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic [94:0] fq[$];
    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    int          coinc = 0;
    int          run_len = 0;
    int          max_run = 0;
    logic        prev_ren = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;

    function automatic logic [94:0] mk(input logic [13:0] peer,
                                       input logic [13:0] loc,
                                       input logic [31:0] off,
                                       input logic [31:0] len,
                                       input logic [2:0]  pr);
        return {peer, loc, off, len, pr};
    endfunction

    function automatic void fifo_refresh();
        grant_pkt_empty_i = (fq.size() == 0);
        if (fq.size() == 0)
            grant_pkt_data_i = {$urandom, $urandom, $urandom};
        else
            grant_pkt_data_i = fq[0];
    endfunction

    function automatic void push_entry(input logic [94:0] e);
        fq.push_back(e);
        fifo_refresh();
    endfunction

    function automatic void push_exp(input logic [63:0] d0,
                                     input logic [63:0] d1,
                                     input logic [63:0] d2);
        beat_t b;
        b.data = d0; b.keep = 8'hFF; b.last = 1'b0; exp_q.push_back(b);
        b.data = d1; b.keep = 8'hFF; b.last = 1'b0; exp_q.push_back(b);
        b.data = d2; b.keep = 8'h80; b.last = 1'b1; exp_q.push_back(b);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // upstream FWFT FIFO: pop decided at the edge, applied just after
    initial begin
        logic p;
        logic c;
        fifo_refresh();
        forever begin
            @(posedge ap_clk);
            p = grant_pkt_read_en_o;
            c = axis.m_axis_tvalid & axis.m_axis_tready & axis.m_axis_tlast;
            #1;
            if (p) begin
                pops++;
                if (c) coinc++;
                if (fq.size() == 0) begin
                    errors++;
                    $display("FAIL pop_on_empty actual=1 required=0");
                end else begin
                    void'(fq.pop_front());
                end
            end
            fifo_refresh();
        end
    end

    // monitor: compares every handshake beat against the scoreboard
    always @(negedge ap_clk) begin
        beat_t e;
        if (!ap_rst_n) begin
            prev_ren   = 1'b0;
            prev_stall = 1'b0;
            run_len    = 0;
        end else begin
`ifndef GRANT_DEDUP_EN
            if (prev_ren) chk("tvalid_after_pop", 64'(axis.m_axis_tvalid), 64'd1);
`endif
            if (prev_stall) chk("stall_hold", axis.m_axis_tdata, prev_data);
            if (axis.m_axis_tvalid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (axis.m_axis_tvalid && axis.m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%h required=none",
                             axis.m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", axis.m_axis_tdata, e.data);
                    chk("beat_keep", 64'(axis.m_axis_tkeep), 64'(e.keep));
                    chk("beat_last", 64'(axis.m_axis_tlast), 64'(e.last));
                end
            end
            prev_ren   = grant_pkt_read_en_o;
            prev_stall = axis.m_axis_tvalid & ~axis.m_axis_tready;
            prev_data  = axis.m_axis_tdata;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(fq.size() == 0 && !axis.m_axis_tvalid
                 && exp_q.size() == 0) && n < 300) begin
            @(negedge ap_clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=%0d required=<300", n);
        end
        @(negedge ap_clk);
    endtask

    task automatic wait_beat1();
        int n;
        n = 0;
        while (exp_q.size() != 2 && n < 100) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL beat1_timeout actual=%0d required=<100", n);
        end
    endtask

    logic [94:0] e1, e2, e3, e4, e5;

    initial begin
        e1 = mk(14'h3, 14'h3333, 32'h10, 32'h100, 3'd2);
        e2 = mk(14'h3FFF, 14'h1, 32'hDEADBEEF, 32'h12345678, 3'd7);
        e3 = mk(14'h155, 14'h2AAA, 32'hCAFE0000, 32'h40, 3'd5);
        e4 = mk(14'h7, 14'h9, 32'h10, 32'h80, 3'd1);
        e5 = mk(14'h7, 14'h9, 32'h20, 32'h80, 3'd1);

        ap_rst_n = 1'b0;
        axis.m_axis_tready = 1'b1;
        repeat (3) @(negedge ap_clk);
        chk("rst_tvalid", 64'(axis.m_axis_tvalid), 64'd0);
        chk("rst_tdata",  axis.m_axis_tdata, 64'd0);
        chk("rst_tkeep",  64'(axis.m_axis_tkeep), 64'd0);
        chk("rst_tlast",  64'(axis.m_axis_tlast), 64'd0);
        chk("rst_count",  64'(grant_sent_count_o), 64'd0);
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;

        // single packet
        push_exp(64'h0003_3333_1100_0000, 64'h0000_0010_0000_0100,
                 64'h0200_0000_0000_0000);
        push_entry(e1);
        wait_idle();
        chk("single_count", 64'(grant_sent_count_o), 64'd1);
        chk("single_pops", 64'(pops), 64'd1);

        // back-to-back pair without bubble
        @(posedge ap_clk);
        #1;
        max_run = 0;
        push_exp(64'h3FFF_0001_1100_0000, 64'hDEADBEEF_12345678,
                 64'h0700_0000_0000_0000);
        push_exp(64'h0155_2AAA_1100_0000, 64'hCAFE0000_00000040,
                 64'h0500_0000_0000_0000);
        push_entry(e2);
        push_entry(e3);
        wait_idle();
        chk("b2b_run", 64'(max_run), 64'd6);
        chk("b2b_coincident_pop", 64'(coinc), 64'd1);
        chk("b2b_count", 64'(grant_sent_count_o), 64'd3);

        // backpressure during BEAT1 with another entry waiting
        @(posedge ap_clk);
        #1;
        push_exp(64'h0003_3333_1100_0000, 64'h0000_0010_0000_0100,
                 64'h0200_0000_0000_0000);
        push_entry(e1);
        wait_beat1();
        axis.m_axis_tready = 1'b0;
        push_exp(64'h3FFF_0001_1100_0000, 64'hDEADBEEF_12345678,
                 64'h0700_0000_0000_0000);
        push_entry(e2);
        repeat (4) begin
            @(negedge ap_clk);
            chk("stall_tdata", axis.m_axis_tdata, 64'h0000_0010_0000_0100);
            chk("stall_tvalid", 64'(axis.m_axis_tvalid), 64'd1);
            chk("stall_no_pop", 64'(grant_pkt_read_en_o), 64'd0);
            @(posedge ap_clk);
            #1;
        end
        axis.m_axis_tready = 1'b1;
        wait_idle();
        chk("stall_count", 64'(grant_sent_count_o), 64'd5);

        // reset in the middle of BEAT1; packet is abandoned
        @(posedge ap_clk);
        #1;
        push_exp(64'h0155_2AAA_1100_0000, 64'hCAFE0000_00000040,
                 64'h0500_0000_0000_0000);
        push_entry(e3);
        wait_beat1();
        ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", 64'(axis.m_axis_tvalid), 64'd0);
        chk("mid_rst_tdata",  axis.m_axis_tdata, 64'd0);
        chk("mid_rst_tkeep",  64'(axis.m_axis_tkeep), 64'd0);
        chk("mid_rst_ren",    64'(grant_pkt_read_en_o), 64'd0);
        chk("mid_rst_count",  64'(grant_sent_count_o), 64'd0);
        exp_q.delete();
        push_exp(64'h0003_3333_1100_0000, 64'h0000_0010_0000_0100,
                 64'h0200_0000_0000_0000);
        push_entry(e1);
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("post_rst_no_pop", 64'(grant_pkt_read_en_o), 64'd0);
        wait_idle();
        chk("post_rst_count", 64'(grant_sent_count_o), 64'd1);

        // repeated entry followed by a different offset
        @(posedge ap_clk);
        #1;
        pops = 0;
        push_exp(64'h0007_0009_1100_0000, 64'h0000_0010_0000_0080,
                 64'h0100_0000_0000_0000);
`ifndef GRANT_DEDUP_EN
        push_exp(64'h0007_0009_1100_0000, 64'h0000_0010_0000_0080,
                 64'h0100_0000_0000_0000);
`endif
        push_exp(64'h0007_0009_1100_0000, 64'h0000_0020_0000_0080,
                 64'h0100_0000_0000_0000);
        push_entry(e4);
        push_entry(e4);
        push_entry(e5);
        wait_idle();
        chk("dup_pops", 64'(pops), 64'd3);
`ifdef GRANT_DEDUP_EN
        chk("dup_count", 64'(grant_sent_count_o), 64'd3);
`else
        chk("dup_count", 64'(grant_sent_count_o), 64'd4);
`endif

        // counter wrap
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        @(posedge ap_clk);
        #1;
        push_exp(64'h0155_2AAA_1100_0000, 64'hCAFE0000_00000040,
                 64'h0500_0000_0000_0000);
        push_entry(e3);
        wait_idle();
        chk("wrap_count", 64'(grant_sent_count_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=done");
        $fatal(1, "timeout");
    end

endmodule
